ibex_register_file_mp: RTL and testbench
========================================

Name: ibex_register_file_mp

Overview:
- Flip-flop based, multi-port register file for the ibex core.
- Configurable read and write port counts, optional same-cycle write-to-read bypass, and one parity bit per word.
- A background scrubber FSM walks all words on request and raises a sticky integrity error.
- Sits between decode (read ports) and the writeback and LSU return paths (write ports). Register x0 is hard-wired.

Parameters:
- RV32E, 0, 1 selects 16 words (4-bit address); 0 selects 32 words.
- DataWidth, 32, data bits per word, excluding parity.
- NumReadPorts, 2, number of combinational read ports (1..4).
- NumWritePorts, 2, number of write ports (1..3).
- WriteBypass, 1, 1 forwards same-cycle write data to matching read ports.
- WordZeroVal, '0, value of x0 and the reset value of every word.

Ports:
- clk_int  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- raddr_i  input  NumReadPorts x 5  read addresses
- rdata_o  output  NumReadPorts x DataWidth  read data
- rdata_perr_o  output  NumReadPorts  parity mismatch on the stored word being read
- waddr_i  input  NumWritePorts x 5  write addresses
- wdata_i  input  NumWritePorts x DataWidth  write data
- we_i  input  NumWritePorts  write enables
- inject_perr_i  input  1  DV/fault hook: store inverted parity for a port-0 write
- scrub_req_i  input  1  start one scrub pass
- scrub_busy_o  output  1  scrub pass in progress
- scrub_done_o  output  1  one-cycle pulse when a pass completes
- wr_conflict_o  output  1  registered pulse: two or more ports wrote the same nonzero address
- err_o  output  1  sticky parity error found by the scrubber

Behaviour:
- NUM_WORDS = RV32E ? 16 : 32. Only the low ADDR_WIDTH address bits are used; upper bits are ignored.
- Storage is words 1..NUM_WORDS-1, each DataWidth+1 flops: data plus even parity (parity bit = XOR of the data bits).
- Reset: every word is set to WordZeroVal with matching parity. err_o, scrub_busy_o, scrub_done_o and wr_conflict_o are 0. FSM goes to IDLE.
- Write: port p writes on the clk_int edge when we_i[p]=1 and waddr != 0. Writes to x0 are dropped silently.
- Same-address writes: the highest-index enabled port wins.
  - wr_conflict_o goes high the next cycle, for 1 cycle.
  - No conflict is reported for address 0.
- inject_perr_i with we_i[0]: port 0's parity bit is inverted. It has no effect if a higher port overrides the write.
- Read: combinational, zero latency.
  - Address 0 returns WordZeroVal and rdata_perr_o=0.
  - Otherwise returns the stored word; rdata_perr_o = stored parity XOR recomputed parity.
- Bypass (WriteBypass=1): if any enabled write port targets the read address (nonzero), rdata_o is that port's wdata (highest index wins) and rdata_perr_o=0.
- No bypass (WriteBypass=0): the old value is read; new data is visible from the next cycle.
- Scrubber FSM states: IDLE, RUN, DONE.
  - IDLE: when scrub_req_i=1, set idx=1 and go to RUN. Requests in RUN or DONE are ignored.
  - RUN: scrub_busy_o=1. Each cycle, check the parity of word idx.
    - A mismatch sets err_o=1 (sticky until reset).
    - If any port writes word idx that cycle, the check is skipped and does not count as an error.
    - idx increments each cycle. At idx = NUM_WORDS-1, after its check, go to DONE.
  - DONE: scrub_done_o=1 and scrub_busy_o=0 for one cycle, then return to IDLE.
  - Timing: a request at cycle T gives scrub_busy_o high for cycles T+1..T+NUM_WORDS-1 and scrub_done_o at T+NUM_WORDS.
- Reset mid-scan: the FSM returns to IDLE, err_o clears, and no done pulse is issued.
- Reads and writes are never stalled by the scrubber; it uses a dedicated internal read mux.

Decomposition:
- Package ibex_rf_pkg holds:
  - the scrub state enum (SCRUB_IDLE, SCRUB_RUN, SCRUB_DONE);
  - the function rf_parity(data);
  - the constants RF_ADDR_W_RV32I=5 and RF_ADDR_W_RV32E=4.
- Sub-module ibex_rf_scrubber contains the FSM, the idx counter and the sticky err. It receives the current word plus per-word write hits; the top level keeps storage and the ports.

Test Plan:
- Reset, then read all addresses on both ports -> rdata_o=0, rdata_perr_o=0, err_o=0.
- Port0 writes x5=0xDEADBEEF, reading x5 the same cycle -> 0xDEADBEEF with WriteBypass=1; the old 0x0 with WriteBypass=0; 0xDEADBEEF the next cycle in both cases.
- Port0 and port1 both write x7 (0x11111111 and 0x22222222) -> x7=0x22222222; wr_conflict_o pulses 1 cycle later; a write to x0 from both ports -> no pulse, x0 reads 0.
- Write x9=0x12345678 with inject_perr_i, then read x9 -> rdata_perr_o=1. scrub_req_i at T -> busy T+1..T+31, err_o=1 by T+9, done at T+32.
- Clean file, scrub, with port1 rewriting the word under scan each cycle -> err_o stays 0 and scrub_done_o still at T+32. Assert rst_ni at T+10 -> busy=0, err=0, no done pulse.
- RV32E=1: write x20 lands in x4; a scrub pass has done at T+16.

Source files
------------

// File: rtl/ibex_rf_pkg.sv
// rtl/ibex_rf_pkg.sv - shared types, constants and parity helper for the multi-port register file
package ibex_rf_pkg;

  localparam int RF_ADDR_W_RV32I = 5;
  localparam int RF_ADDR_W_RV32E = 4;
  // Widest word the parity helper accepts; callers zero-extend, which leaves the XOR unchanged.
  localparam int RF_PARITY_MAX_W = 64;

  typedef enum logic [1:0] {
    SCRUB_IDLE,
    SCRUB_RUN,
    SCRUB_DONE
  } scrub_state_e;

  // Even parity: the stored bit is the XOR of all data bits.
  function automatic logic rf_parity(input logic [RF_PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ibex_rf_scrubber.sv
// rtl/ibex_rf_scrubber.sv - background parity scrubber walking words 1..NumWords-1
module ibex_rf_scrubber
  import ibex_rf_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int NumWords  = 32,
  parameter int AddrW     = 5
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 i_req,
  input  logic [DataWidth:0]   i_word,
  input  logic [NumWords-1:0]  i_wr_hit,
  output logic [AddrW-1:0]     o_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  scrub_state_e     r_state, w_state_next;
  logic [AddrW-1:0] r_idx, w_idx_next;
  logic             r_err, w_err_next;
  logic             w_mismatch;

  assign w_mismatch = i_word[DataWidth] ^ rf_parity(RF_PARITY_MAX_W'(i_word[DataWidth-1:0]));
  assign o_idx      = r_idx;
  // The error is visible already in the cycle the bad word is checked, then held by r_err.
  assign o_err      = w_err_next;

  // State, scan index and sticky error registers.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SCRUB_IDLE;
      r_idx   <= AddrW'(1);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state, index advance and error detection; a word being written this cycle is not judged.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_err_next   = r_err;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      SCRUB_IDLE: begin
        if (i_req) begin
          w_idx_next   = AddrW'(1);
          w_state_next = SCRUB_RUN;
        end
      end
      SCRUB_RUN: begin
        o_busy = 1'b1;
        if (!i_wr_hit[r_idx] && w_mismatch) begin
          w_err_next = 1'b1;
        end
        if (r_idx == AddrW'(NumWords - 1)) begin
          w_state_next = SCRUB_DONE;
        end else begin
          w_idx_next = r_idx + AddrW'(1);
        end
      end
      SCRUB_DONE: begin
        o_done       = 1'b1;
        w_state_next = SCRUB_IDLE;
      end
      default: w_state_next = SCRUB_IDLE;
    endcase
  end

endmodule

// File: rtl/ibex_register_file_mp.sv
// rtl/ibex_register_file_mp.sv - flop-based multi-port register file with parity, bypass and scrubber
module ibex_register_file_mp
  import ibex_rf_pkg::*;
#(
  parameter bit                   RV32E         = 1'b0,
  parameter int                   DataWidth     = 32,
  parameter int                   NumReadPorts  = 2,
  parameter int                   NumWritePorts = 2,
  parameter bit                   WriteBypass   = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                              clk_int,
  input  logic                              rst_ni,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]           rdata_perr_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic                              inject_perr_i,
  input  logic                              scrub_req_i,
  output logic                              scrub_busy_o,
  output logic                              scrub_done_o,
  output logic                              wr_conflict_o,
  output logic                              err_o
);

  localparam int   NumWords    = RV32E ? 16 : 32;
  localparam int   AddrW       = RV32E ? RF_ADDR_W_RV32E : RF_ADDR_W_RV32I;
  localparam logic WordZeroPar = rf_parity(RF_PARITY_MAX_W'(WordZeroVal));

  // Word 0 has no storage: x0 is hard-wired to WordZeroVal.
  logic [DataWidth:0]  r_mem      [1:NumWords-1];
  logic [DataWidth:0]  w_mem_next [1:NumWords-1];
  logic [NumWords-1:0] w_wr_hit;
  logic [AddrW-1:0]    w_waddr    [NumWritePorts];
  logic [AddrW-1:0]    w_raddr    [NumReadPorts];
  logic                w_conflict;
  logic                r_wr_conflict;
  logic [AddrW-1:0]    w_scrub_idx;
  logic [DataWidth:0]  w_scrub_word;
  logic                w_unused_addr;

  // Upper address bits are ignored for RV32E.
  assign w_unused_addr = ^{raddr_i, waddr_i};

  // Extract the used low address bits of every port.
  always_comb begin
    for (int p = 0; p < NumWritePorts; p++) w_waddr[p] = waddr_i[p*5 +: AddrW];
    for (int r = 0; r < NumReadPorts; r++)  w_raddr[r] = raddr_i[r*5 +: AddrW];
  end

  // Per-word write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    w_wr_hit = '0;
    for (int w = 1; w < NumWords; w++) begin
      w_mem_next[w] = r_mem[w];
      for (int p = 0; p < NumWritePorts; p++) begin
        if (we_i[p] && (w_waddr[p] == AddrW'(w))) begin
          w_wr_hit[w]   = 1'b1;
          w_mem_next[w] = {rf_parity(RF_PARITY_MAX_W'(wdata_i[p*DataWidth +: DataWidth]))
                             ^ ((p == 0) && inject_perr_i),
                           wdata_i[p*DataWidth +: DataWidth]};
        end
      end
    end
  end

  // Word storage with parity.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 1; w < NumWords; w++) r_mem[w] <= {WordZeroPar, WordZeroVal};
    end else begin
      for (int w = 1; w < NumWords; w++) begin
        if (w_wr_hit[w]) r_mem[w] <= w_mem_next[w];
      end
    end
  end

  // Any pair of enabled ports on the same nonzero address is a conflict.
  always_comb begin
    w_conflict = 1'b0;
    for (int p = 0; p < NumWritePorts; p++) begin
      for (int q = p + 1; q < NumWritePorts; q++) begin
        if (we_i[p] && we_i[q] && (w_waddr[p] == w_waddr[q]) && (w_waddr[p] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Conflict is reported one cycle after the offending writes.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) r_wr_conflict <= 1'b0;
    else         r_wr_conflict <= w_conflict;
  end

  assign wr_conflict_o = r_wr_conflict;

  // Combinational read ports with optional same-cycle forwarding of write data.
  always_comb begin
    rdata_o      = '0;
    rdata_perr_o = '0;
    for (int r = 0; r < NumReadPorts; r++) begin
      rdata_o[r*DataWidth +: DataWidth] = WordZeroVal;
      if (w_raddr[r] != '0) begin
        rdata_o[r*DataWidth +: DataWidth] = r_mem[w_raddr[r]][DataWidth-1:0];
        rdata_perr_o[r] = r_mem[w_raddr[r]][DataWidth]
                          ^ rf_parity(RF_PARITY_MAX_W'(r_mem[w_raddr[r]][DataWidth-1:0]));
        if (WriteBypass) begin
          for (int p = 0; p < NumWritePorts; p++) begin
            if (we_i[p] && (w_waddr[p] == w_raddr[r])) begin
              rdata_o[r*DataWidth +: DataWidth] = wdata_i[p*DataWidth +: DataWidth];
              rdata_perr_o[r] = 1'b0;
            end
          end
        end
      end
    end
  end

  // The scrubber index never reaches 0, so the dedicated mux stays within storage.
  assign w_scrub_word = r_mem[w_scrub_idx];

  ibex_rf_scrubber #(
    .DataWidth (DataWidth),
    .NumWords  (NumWords),
    .AddrW     (AddrW)
  ) u_scrubber (
    .clk_int  (clk_int),
    .rst_ni   (rst_ni),
    .i_req    (scrub_req_i),
    .i_word   (w_scrub_word),
    .i_wr_hit (w_wr_hit),
    .o_idx    (w_scrub_idx),
    .o_busy   (scrub_busy_o),
    .o_done   (scrub_done_o),
    .o_err    (err_o)
  );

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb/tb_ibex_register_file_mp.sv - directed scoreboard bench for ibex_register_file_mp
module tb_ibex_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  raddr, waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        inject, req;

  logic [63:0] rd_a, rd_b, rd_e;
  logic [1:0]  pe_a, pe_b, pe_e;
  logic        busy_a, done_a, conf_a, err_a;
  logic        busy_b, done_b, conf_b, err_b;
  logic        busy_e, done_e, conf_e, err_e;

  int          total = 0;
  int          bad = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ibex_register_file_mp u_dut_a (
    .clk_int(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rd_a), .rdata_perr_o(pe_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .inject_perr_i(inject), .scrub_req_i(req),
    .scrub_busy_o(busy_a), .scrub_done_o(done_a), .wr_conflict_o(conf_a), .err_o(err_a));

  ibex_register_file_mp #(.WriteBypass(1'b0)) u_dut_b (
    .clk_int(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rd_b), .rdata_perr_o(pe_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .inject_perr_i(inject), .scrub_req_i(req),
    .scrub_busy_o(busy_b), .scrub_done_o(done_b), .wr_conflict_o(conf_b), .err_o(err_b));

  ibex_register_file_mp #(.RV32E(1'b1)) u_dut_e (
    .clk_int(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rd_e), .rdata_perr_o(pe_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .inject_perr_i(inject), .scrub_req_i(req),
    .scrub_busy_o(busy_e), .scrub_done_o(done_e), .wr_conflict_o(conf_e), .err_o(err_e));

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic clr_w();
    we = 2'b00; inject = 1'b0; req = 1'b0; waddr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_w();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_w();
    raddr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state and clean reads of every address on both ports
    @(negedge clk); #1;
    push("rst_err", 0);  chk(err_a);
    push("rst_busy", 0); chk(busy_a);
    push("rst_done", 0); chk(done_a);
    push("rst_conf", 0); chk(conf_a);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      raddr = {5'(31 - a), 5'(a)};
      #1;
      push($sformatf("rst_rd0_x%0d", a), 0); chk(rd_a[31:0]);
      push($sformatf("rst_rd1_x%0d", 31 - a), 0); chk(rd_a[63:32]);
      push($sformatf("rst_perr_x%0d", a), 0); chk(32'(pe_a));
    end

    // same-cycle write/read, with and without bypass
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    #1;
    push("bypass_same", 32'hDEADBEEF); chk(rd_a[31:0]);
    push("bypass_perr", 0);            chk(32'(pe_a[0]));
    push("nobypass_same", 0);          chk(rd_b[31:0]);
    @(negedge clk); clr_w(); #1;
    push("bypass_next", 32'hDEADBEEF);   chk(rd_a[31:0]);
    push("nobypass_next", 32'hDEADBEEF); chk(rd_b[31:0]);

    // both ports write x7: highest port wins, conflict pulses once
    @(negedge clk);
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111}; raddr = {5'd7, 5'd7};
    #1;
    push("conf_same_cycle", 0);       chk(conf_a);
    push("bypass_x7", 32'h22222222);  chk(rd_a[31:0]);
    @(negedge clk); clr_w(); #1;
    push("conf_pulse", 1);            chk(conf_a);
    push("x7_winner", 32'h22222222);  chk(rd_a[31:0]);
    push("x7_winner_nb", 32'h22222222); chk(rd_b[63:32]);
    @(negedge clk);
    we = 2'b11; waddr = '0; wdata = {32'h33333333, 32'h44444444}; raddr = '0;
    #1;
    push("conf_pulse_end", 0); chk(conf_a);
    push("x0_bypass", 0);      chk(rd_a[31:0]);
    @(negedge clk); clr_w(); #1;
    push("conf_x0", 0);        chk(conf_a);
    push("x0_read", 0);        chk(rd_a[63:32]);

    // parity injection then a scrub pass
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h12345678; inject = 1'b1;
    @(negedge clk); clr_w(); raddr = {5'd0, 5'd9}; #1;
    push("inj_perr", 1);           chk(32'(pe_a[0]));
    push("inj_data", 32'h12345678); chk(rd_a[31:0]);
    @(negedge clk); req = 1'b1; #1;
    push("scrub_t_busy", 0); chk(busy_a);
    push("scrub_t_err", 0);  chk(err_a);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk); req = 1'b0; #1;
      push($sformatf("scrub_busy_t%0d", k), 32'(k <= 31)); chk(busy_a);
      push($sformatf("scrub_done_t%0d", k), 32'(k == 32)); chk(done_a);
      if (k == 10) begin push("scrub_err_t10", 1); chk(err_a); end
    end
    @(negedge clk); #1;
    push("scrub_done_clear", 0); chk(done_a);
    push("scrub_err_sticky", 1); chk(err_a);

    // corrupted word rewritten during its own check slot is not an error
    do_reset();
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'hCAFE0009; inject = 1'b1;
    @(negedge clk); clr_w(); raddr = {5'd0, 5'd9}; #1;
    push("inj2_perr", 1); chk(32'(pe_a[0]));
    @(negedge clk); req = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k <= 31) begin
        we = 2'b10; waddr[9:5] = 5'(k); wdata[63:32] = 32'(k) * 32'h01010101;
      end else begin
        clr_w();
      end
      #1;
      push($sformatf("skip_err_t%0d", k), 0); chk(err_a);
      push($sformatf("skip_done_t%0d", k), 32'(k == 32)); chk(done_a);
    end
    @(negedge clk); clr_w(); #1;
    push("skip_err_after", 0); chk(err_a);
    push("skip_x9_perr", 0);   chk(32'(pe_a[0]));

    // reset in the middle of a pass
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h0BAD0003; inject = 1'b1;
    @(negedge clk); clr_w();
    @(negedge clk); req = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (k == 10) rst_n = 1'b0;
      if (k == 12) rst_n = 1'b1;
      #1;
      if (k == 5) begin push("mid_err_set", 1); chk(err_a); end
      if (k == 10) begin
        push("mid_rst_busy", 0); chk(busy_a);
        push("mid_rst_err", 0);  chk(err_a);
      end
      if (k >= 10) begin push($sformatf("mid_no_done_t%0d", k), 0); chk(done_a); end
    end

    // RV32E: upper address bit ignored, 16-word scrub pass
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd20; wdata[31:0] = 32'hA5A5A5A5;
    @(negedge clk); clr_w(); raddr = {5'd20, 5'd4}; #1;
    push("e_x4", 32'hA5A5A5A5);  chk(rd_e[31:0]);
    push("e_x20", 32'hA5A5A5A5); chk(rd_e[63:32]);
    push("i_x4", 0);             chk(rd_a[31:0]);
    @(negedge clk); req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); req = 1'b0; #1;
      push($sformatf("e_busy_t%0d", k), 32'(k <= 15)); chk(busy_e);
      push($sformatf("e_done_t%0d", k), 32'(k == 16)); chk(done_e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
